// File: rtl/dual_down_split.sv
`default_nettype none
// ============================================================================
//  Module   : dual_down_split
//  Purpose  : Splits a loaded total into a ceiling half (counter A) and a
//             floor half (counter B), then counts A down to zero followed by
//             B down to zero, pulsing done for one cycle at the end. A total
//             too large for two W-bit halves saturates both halves and raises
//             ovf.
//  Ports    : clk    - clock, rising-edge active
//             clr_n  - asynchronous active-low reset
//             load   - start request, honoured only while idle
//             total  - W+1 bit value to split, sampled with load
//             en     - count enable; low freezes the countdown phases
//             out    - counter A (registered)
//             out1   - counter B (registered)
//             resto  - out + out1, full W+1 bit sum
//             busy   - high while either counter phase is active
//             done   - one-cycle completion pulse
//             ovf    - last loaded total did not fit (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module dual_down_split #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W:0]   total,
    input  logic         en,
    output logic [W-1:0] out,
    output logic [W-1:0] out1,
    output logic [W:0]   resto,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COUNT_A = 2'd1;
    localparam logic [1:0] c_COUNT_B = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    // Largest total that splits into two W-bit halves: 2*(2^W-1).
    localparam logic [W:0]   c_MAX  = {{W{1'b1}}, 1'b0};
    localparam logic [W-1:0] c_ONES = {W{1'b1}};
    localparam logic [W-1:0] c_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]   r_state;
    logic [W-1:0] r_out;
    logic [W-1:0] r_out1;
    logic         r_ovf;

    logic [1:0]   w_state_nxt;
    logic [W-1:0] w_out_nxt;
    logic [W-1:0] w_out1_nxt;
    logic         w_ovf_nxt;
    logic [W-1:0] w_ceil_half;
    logic [W-1:0] w_floor_half;

    // floor(total/2) is a plain shift; the ceiling adds back the dropped LSB.
    // Only evaluated for in-range totals, where the ceiling fits in W bits.
    assign w_floor_half = total[W:1];
    assign w_ceil_half  = total[W:1] + {{(W-1){1'b0}}, total[0]};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= c_IDLE;
            r_out   <= '0;
            r_out1  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_out1  <= w_out1_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_out1_nxt  = r_out1;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            c_IDLE: begin
                // A load starts the operation even with en low.
                if (load) begin
                    w_state_nxt = c_COUNT_A;
                    if (total > c_MAX) begin
                        w_out_nxt  = c_ONES;
                        w_out1_nxt = c_ONES;
                        w_ovf_nxt  = 1'b1;
                    end else begin
                        w_out_nxt  = w_ceil_half;
                        w_out1_nxt = w_floor_half;
                        w_ovf_nxt  = 1'b0;
                    end
                end
            end
            c_COUNT_A: begin
                // Reaching zero costs one extra enabled cycle to hand over.
                if (en) begin
                    if (r_out != '0) begin
                        w_out_nxt = r_out - c_ONE;
                    end else begin
                        w_state_nxt = c_COUNT_B;
                    end
                end
            end
            c_COUNT_B: begin
                if (en) begin
                    if (r_out1 != '0) begin
                        w_out1_nxt = r_out1 - c_ONE;
                    end else begin
                        w_state_nxt = c_DONE;
                    end
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign out   = r_out;
    assign out1  = r_out1;
    assign ovf   = r_ovf;
    assign resto = {1'b0, r_out} + {1'b0, r_out1};
    assign busy  = (r_state == c_COUNT_A) || (r_state == c_COUNT_B);
    assign done  = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dual_down_split.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_down_split
//  Purpose  : Self-checking bench for dual_down_split. Expected outputs come
//             from an arithmetic model: after k enabled edges past a load of
//             halves (a, b), counter A shows a-k until it is spent, then one
//             hand-over edge, then counter B counts down, then one done cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dual_down_split;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         load;
    logic [W:0]   total;
    logic         en;
    logic [W-1:0] out;
    logic [W-1:0] out1;
    logic [W:0]   resto;
    logic         busy;
    logic         done;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ovf    = 0;

    dual_down_split #(.W(W)) u_dut (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (load),
        .total (total),
        .en    (en),
        .out   (out),
        .out1  (out1),
        .resto (resto),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_outputs(input string tag, input int eo, input int eo1,
                                  input int eb, input int ed);
        check({tag, " out"},   32'(out),   eo);
        check({tag, " out1"},  32'(out1),  eo1);
        check({tag, " resto"}, 32'(resto), eo + eo1);
        check({tag, " busy"},  32'(busy),  eb);
        check({tag, " done"},  32'(done),  ed);
        check({tag, " ovf"},   32'(ovf),   m_ovf);
    endtask

    // mode 0: en always high; 1: en random (70%); 2: en low for 3 cycles
    // while counter A shows 3. noise drives random load with total=20 while
    // the operation runs. lat returns the edge count from load to DONE entry.
    task automatic run_op(input int t, input int mode, input bit noise, output int lat);
        int a, b, k, stall, cyc, tv;
        bit in_done;
        m_ovf = (t > 2 * ((1 << W) - 1)) ? 1 : 0;
        a = m_ovf ? (1 << W) - 1 : (t + 1) / 2;
        b = m_ovf ? (1 << W) - 1 : t / 2;
        tv    = t;
        load  = 1'b1;
        total = tv[W:0];
        en    = ($urandom % 2) == 1;
        @(posedge clk); #1;
        expect_outputs("load", a, b, 1, 0);
        k = 0; stall = 0; cyc = 0; lat = -1; in_done = 1'b0;
        forever begin
            case (mode)
                0: en = 1'b1;
                1: en = ($urandom % 100) < 70;
                default: begin
                    if (!in_done && k <= a && (a - k) == 3 && stall < 3) begin
                        en = 1'b0;
                        stall++;
                    end else begin
                        en = 1'b1;
                    end
                end
            endcase
            load = noise ? (($urandom % 2) == 1) : 1'b0;
            tv = noise ? 20 : int'($urandom % 128);
            total = tv[W:0];
            @(posedge clk); #1;
            cyc++;
            if (in_done) begin
                expect_outputs("back_idle", 0, 0, 0, 0);
                break;
            end
            if (en) k++;
            if (k <= a) begin
                expect_outputs("cnt_a", a - k, b, 1, 0);
            end else if (k <= a + b + 1) begin
                expect_outputs("cnt_b", 0, b - (k - a - 1), 1, 0);
            end else begin
                expect_outputs("done", 0, 0, 0, 1);
                in_done = 1'b1;
                lat = cyc;
            end
            if (cyc > 1000) begin
                check("timeout", 0, 1);
                break;
            end
        end
        // Idle with no load: final values and ovf must hold.
        load = 1'b0;
        en   = ($urandom % 2) == 1;
        @(posedge clk); #1;
        expect_outputs("hold", 0, 0, 0, 0);
    endtask

    initial begin
        int lat;
        int t;
        clr_n = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        total = '0;
        #2;
        m_ovf = 0;
        expect_outputs("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        run_op(10, 0, 1'b0, lat);
        check("lat_10", lat, 12);
        run_op(11, 0, 1'b0, lat);
        check("lat_11", lat, 13);
        run_op(127, 0, 1'b0, lat);
        check("lat_127", lat, 128);
        run_op(4, 0, 1'b0, lat);
        check("lat_4", lat, 6);
        run_op(0, 0, 1'b0, lat);
        check("lat_0", lat, 2);
        run_op(126, 0, 1'b0, lat);
        check("lat_126", lat, 128);
        run_op(10, 2, 1'b0, lat);
        check("lat_stall", lat, 15);
        run_op(9, 0, 1'b1, lat);
        check("lat_noise", lat, 11);

        // Reset in the middle of counter A, then restart right after release.
        load  = 1'b1;
        total = 7'd10;
        en    = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst out", 32'(out), 2);
        #2;
        clr_n = 1'b0;
        #1;
        m_ovf = 0;
        expect_outputs("async_rst", 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
            expect_outputs("in_rst", 0, 0, 0, 0);
        end
        @(negedge clk);
        clr_n = 1'b1;
        run_op(6, 0, 1'b0, lat);
        check("lat_after_rst", lat, 8);

        for (int i = 0; i < 20; i++) begin
            t = int'($urandom % 128);
            run_op(t, 1, ($urandom % 2) == 1, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
